btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Conditions a raw asynchronous push-button or switch input before it drives the `d` input of the `ffd` stage and the later examples on the EDU-CIAA-FPGA board.
- Synchronises the input into the `clk` domain with a 2-flop synchroniser.
- Filters contact bounce by requiring the input to hold a new value for `STABLE_CYCLES` consecutive cycles.
- Provides a clean level output plus single-cycle rise and fall pulses.

Parameters:
- STABLE_CYCLES, 12000, consecutive cycles the synchronised input must differ from `level` before `level` changes (1 ms at 12 MHz). Legal range is at least 1.
- ACTIVE_LOW, 0, when 1 the raw input is inverted before the synchroniser, so a pressed (low) button reads as logical 1.
- CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter. It is derived; overriding it is not allowed.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_in  input  1  raw asynchronous pad input; may bounce or glitch at any time.
- level  output  1  debounced logical level.
- rise  output  1  one-cycle pulse when `level` goes 0→1.
- fall  output  1  one-cycle pulse when `level` goes 1→0.

Behaviour:
- Input conditioning: `raw_l = btn_in ^ ACTIVE_LOW`.
- Synchroniser: `s1 <= raw_l; s2 <= s1`. Only `s2` is used downstream; `btn_in` never reaches any other logic.
- Reset (`rst`=1 at a rising edge):
  - `s1`, `s2`, `cnt`, `level`, `rise` and `fall` all become 0, i.e. logical released.
  - `rst` has priority over all other updates.
  - Reset mid-count discards the count. Reset while `level`=1 drops `level` to 0 with no `fall` pulse.
- Per-cycle update when not in reset (`rise` and `fall` default to 0 every cycle):
  - If `s2 == level`: `cnt <= 0`.
  - Else if `cnt == STABLE_CYCLES-1`: `level <= s2`, `cnt <= 0`, and `rise <= s2`, `fall <= ~s2`.
  - Else: `cnt <= cnt+1`.
- Latency: `raw_l` is stable from before edge E0. `level` and the matching pulse become visible after edge E0+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges total.
- Pulse alignment: `rise`/`fall` are high for exactly one cycle, in the same cycle `level` first shows its new value. `rise` and `fall` are never high together.
- Bounce: any cycle where `s2` equals `level` clears `cnt`. Glitches of STABLE_CYCLES-1 cycles or fewer (as seen on `s2`) never change `level`.
- Counter range: `cnt` never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- STABLE_CYCLES=1: `level` follows `s2` with one extra cycle of delay; pulses still behave as above.
- Held input: no repeat pulses; `level` stays put and `cnt` stays 0.
- Outputs are registered, with no combinational path from any input to any output.

Test Plan (STABLE_CYCLES=4, ACTIVE_LOW=0 unless noted):
- Reset: hold `rst`=1 for 3 cycles with `btn_in`=1 → `level`=`rise`=`fall`=0 throughout. Release `rst` with `btn_in`=1 → `level`=1 and `rise`=1 exactly 6 edges after the first non-reset edge.
- Clean press/release: `btn_in` 0→1 before edge 0 → `rise` high only in the cycle after edge 5, `level`=1 from then on. `btn_in` 1→0 later → `fall` pulses once after 6 edges and `level` returns to 0.
- Bounce: `btn_in` pattern 1,0,1,1,0,1 one cycle each, then held 1 → no `level` change during the pattern; single `rise` 6 edges after the last 0→1 transition.
- Sub-threshold glitch: `btn_in`=1 for 3 cycles then 0 → `level`, `rise` and `fall` stay 0 for 20 cycles.
- Reset mid-operation: press, assert `rst` for 1 cycle after edge 3 → `level` stays 0, `cnt` restarts. With `btn_in` still 1, `rise` occurs 6 edges after `rst` deasserts.
- ACTIVE_LOW=1: `btn_in` held 1 → `level`=0. Drive `btn_in`=0 → `rise` and `level`=1 after 6 edges. Return `btn_in`=1 → `fall` after 6 edges.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debouncer,
// registered level output with single-cycle rise and fall pulses.
module btn_debounce #(
    parameter int STABLE_CYCLES = 12000,
    parameter bit ACTIVE_LOW    = 1'b0,
    localparam int CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_param
            $error("btn_debounce: STABLE_CYCLES must be at least 1");
        end
    endgenerate

    logic             raw_l;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    assign raw_l = btn_in ^ ACTIVE_LOW;

    // Any cycle where s2 agrees with level restarts the stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw_l;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s2;
                cnt   <= '0;
                rise  <= s2;
                fall  <= ~s2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed test-plan steps plus random bursts,
// checked against a sliding-window reference model of the debouncer.
module tb_btn_debounce;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn_a;
    logic btn_b;
    logic level_a, rise_a, fall_a;
    logic level_b, rise_b, fall_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, one slot per instance (0: active-high, 1: active-low)
    logic          m_s1   [2];
    logic          m_s2   [2];
    logic          m_lvl  [2];
    logic          m_rise [2];
    logic          m_fall [2];
    logic [SC-1:0] m_hist [2];
    int            m_fill [2];

    always #5 clk = ~clk;

    btn_debounce #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_a),
        .level(level_a), .rise(rise_a), .fall(fall_a)
    );

    btn_debounce #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_b),
        .level(level_b), .rise(rise_b), .fall(fall_b)
    );

    // Level flips once the last SC synchronised samples all disagree with it.
    task automatic model_edge(input int i, input logic raw_l, input logic r);
        logic used;
        if (r) begin
            m_s1[i]   = 1'b0;
            m_s2[i]   = 1'b0;
            m_lvl[i]  = 1'b0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_hist[i] = '0;
            m_fill[i] = 0;
        end else begin
            used      = m_s2[i];
            m_s2[i]   = m_s1[i];
            m_s1[i]   = raw_l;
            m_hist[i] = {m_hist[i][SC-2:0], used};
            if (m_fill[i] < SC) m_fill[i]++;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (m_fill[i] == SC && m_hist[i] == {SC{~m_lvl[i]}}) begin
                m_lvl[i]  = ~m_lvl[i];
                m_rise[i] = m_lvl[i];
                m_fall[i] = ~m_lvl[i];
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic a, input logic b, input logic r);
        btn_a = a;
        btn_b = b;
        rst   = r;
        @(posedge clk);
        model_edge(0, a, r);
        model_edge(1, ~b, r);
        @(negedge clk);
        chk("level_a", level_a, m_lvl[0]);
        chk("rise_a",  rise_a,  m_rise[0]);
        chk("fall_a",  fall_a,  m_fall[0]);
        chk("level_b", level_b, m_lvl[1]);
        chk("rise_b",  rise_b,  m_rise[1]);
        chk("fall_b",  fall_b,  m_fall[1]);
        chk("excl_a",  rise_a & fall_a, 1'b0);
        chk("excl_b",  rise_b & fall_b, 1'b0);
    endtask

    initial begin
        logic a;
        logic r;
        int   len;
        logic bounce [6];

        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 2; i++) model_edge(i, 1'b0, 1'b1);
        btn_a = 1'b0;
        btn_b = 1'b1;
        rst   = 1'b1;

        // Reset held with the button pressed
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk("rst_level", level_a, 1'b0);
            chk("rst_rise",  rise_a,  1'b0);
        end
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("rel_rise",  rise_a,  i == 6);
            chk("rel_level", level_a, i == 6);
        end

        // Held input: no repeat pulses, then clean release
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        chk("held_level", level_a, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("clean_fall",  fall_a,  i == 6);
            chk("clean_level", level_a, i != 6);
        end

        // Bounce pattern then hold 1
        for (int i = 0; i < 6; i++) begin
            step(bounce[i], 1'b1, 1'b0);
            chk("bounce_level", level_a, 1'b0);
        end
        for (int i = 2; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("bounce_rise", rise_a, i == 6);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        chk("bounce_rel", level_a, 1'b0);

        // Sub-threshold glitch of SC-1 cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("glitch_level", level_a, 1'b0);
            chk("glitch_rise",  rise_a,  1'b0);
        end

        // Reset in the middle of a count
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("midrst_level", level_a, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("midrst_rise", rise_a, i == 6);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_no_fall", fall_a, 1'b0);
        chk("rst_drop",    level_a, 1'b0);

        // Active-low instance: held high reads released
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        chk("al_idle", level_b, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("al_rise", rise_b, i == 6);
        end
        chk("al_level", level_b, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("al_fall", fall_b, i == 6);
        end

        // Random bursts of varying length with rare resets
        for (int n = 0; n < 300; n++) begin
            a   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * SC);
            for (int k = 0; k < len; k++) begin
                r = ($urandom_range(0, 99) == 0);
                step(a, ~a ^ 1'($urandom_range(0, 3) == 0), r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
